// File: rtl/data_structs.sv
// Shared fixed-point ray/box types and tracer FSM encoding.
// All distances are signed 18.18 fixed point held in 36 bits.
package data_structs;

    localparam int FX_W = 36;

    typedef logic signed [FX_W-1:0] fx_t;

    typedef struct packed {
        fx_t x;
        fx_t y;
        fx_t z;
    } vec3_18_18;

    typedef struct packed {
        vec3_18_18 lo;
        vec3_18_18 hi;
    } bbox;

    typedef struct packed {
        fx_t t_min;
        fx_t t_max;
    } range;

    localparam fx_t T_MIN = '0;
    localparam fx_t T_MAX = fx_t'({1'b0, {(FX_W-1){1'b1}}});

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } tracer_state_e;

endpackage

// File: rtl/multi_box_tracer.sv
// Walks the box table for one ray, issues a slab-test request per box and keeps the
// closest hit. Defining ANY_HIT_EN switches to first-hit early exit.
module multi_box_tracer
    import data_structs::*;
#(
    parameter int NUM_BOXES = 8,
    parameter int IDX_W     = $clog2(NUM_BOXES)
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             ray_in_valid,
    output logic             ray_in_ready,
    input  vec3_18_18        ray_in_orig,
    input  vec3_18_18        ray_in_inv_dir,
    input  logic [19:0]      ray_in_tag,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  bbox              cfg_box,
    input  logic             cfg_count_we,
    input  logic [IDX_W:0]   cfg_count,
    output logic             isect_req_valid,
    input  logic             isect_req_ready,
    output vec3_18_18        isect_req_orig,
    output vec3_18_18        isect_req_inv_dir,
    output bbox              isect_req_box,
    output range             isect_req_range,
    input  logic             isect_rsp_valid,
    input  logic             isect_rsp_hit,
    input  logic [35:0]      isect_rsp_t,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_hit,
    output logic [IDX_W-1:0] res_idx,
    output logic [35:0]      res_t,
    output logic [19:0]      res_tag,
    output logic             err_stray,
    output tracer_state_e    dbg_state
);

    localparam int              CNT_W     = IDX_W + 1;
    localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(NUM_BOXES);

    // Every channel is valid/ready: a transfer happens on the rising edge where both are
    // high, and the sender holds valid and payload unchanged until that edge.
    tracer_state_e    state_q, state_d;
    vec3_18_18        orig_q, orig_d, inv_dir_q, inv_dir_d;
    logic [19:0]      tag_q, tag_d;
    logic             best_hit_q, best_hit_d;
    fx_t              best_t_q, best_t_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [CNT_W-1:0] issue_idx_q, issue_idx_d;
    logic [CNT_W-1:0] rsp_idx_q, rsp_idx_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] box_count_q, box_count_d;
    logic             err_stray_q, err_stray_d;
    bbox              box_table_q [NUM_BOXES];

    logic             ray_fire, req_fire, rsp_take, rsp_stray;
    logic             last_issue, better, take_hit, stop_early;
    logic [IDX_W-1:0] issue_sel;
    bbox              req_box;

    assign ray_fire   = ray_in_valid && ray_in_ready;
    assign req_fire   = isect_req_valid && isect_req_ready;
    assign rsp_take   = isect_rsp_valid && (outstanding_q != '0);
    assign rsp_stray  = isect_rsp_valid && (outstanding_q == '0);
    assign last_issue = req_fire && (issue_idx_q == box_count_q - CNT_W'(1));
    assign take_hit   = rsp_take && isect_rsp_hit && better;
    assign issue_sel  = issue_idx_q[IDX_W-1:0];

`ifdef ANY_HIT_EN
    assign better     = !best_hit_q;
    assign stop_early = take_hit;
`else
    // Strict less-than so an equal distance never displaces the earlier (lower) index.
    assign better     = !best_hit_q || ($signed(isect_rsp_t) < best_t_q);
    assign stop_early = 1'b0;
`endif

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ray_fire) state_d = (box_count_q == '0) ? DONE : ISSUE;
            ISSUE:   if (last_issue || stop_early) state_d = DRAIN;
            DRAIN:   if (outstanding_q == '0) state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ray_in_ready    = (state_q == IDLE);
        isect_req_valid = (state_q == ISSUE);
        res_valid       = (state_q == DONE);
        res_hit         = 1'b0;
        res_idx         = '0;
        res_t           = '0;
        res_tag         = '0;
        if (state_q == DONE) begin
            res_hit = best_hit_q;
            res_idx = best_idx_q;
            res_t   = best_t_q;
            res_tag = tag_q;
        end
    end

    always_comb begin
        req_box = '0;
        if ({1'b0, issue_sel} < MAX_COUNT) req_box = box_table_q[issue_sel];
    end

    assign isect_req_orig    = orig_q;
    assign isect_req_inv_dir = inv_dir_q;
    assign isect_req_box     = req_box;
    assign isect_req_range   = '{t_min: T_MIN, t_max: T_MAX};
    assign err_stray         = err_stray_q;
    assign dbg_state         = state_q;

    always_comb begin
        orig_d        = orig_q;
        inv_dir_d     = inv_dir_q;
        tag_d         = tag_q;
        best_hit_d    = best_hit_q;
        best_t_d      = best_t_q;
        best_idx_d    = best_idx_q;
        issue_idx_d   = issue_idx_q;
        rsp_idx_d     = rsp_idx_q;
        outstanding_d = outstanding_q;
        box_count_d   = box_count_q;
        err_stray_d   = err_stray_q || rsp_stray;
        if (ray_fire) begin
            orig_d        = ray_in_orig;
            inv_dir_d     = ray_in_inv_dir;
            tag_d         = ray_in_tag;
            best_hit_d    = 1'b0;
            best_t_d      = T_MAX;
            best_idx_d    = '0;
            issue_idx_d   = '0;
            rsp_idx_d     = '0;
            outstanding_d = '0;
        end else begin
            if (req_fire) issue_idx_d = issue_idx_q + CNT_W'(1);
            if (rsp_take) rsp_idx_d = rsp_idx_q + CNT_W'(1);
            case ({req_fire, rsp_take})
                2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
                2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
                default: outstanding_d = outstanding_q;
            endcase
            if (take_hit) begin
                best_hit_d = 1'b1;
                best_t_d   = $signed(isect_rsp_t);
                best_idx_d = rsp_idx_q[IDX_W-1:0];
            end
        end
        if (ray_in_ready && cfg_count_we) begin
            box_count_d = (cfg_count > MAX_COUNT) ? MAX_COUNT : cfg_count;
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            orig_q        <= '0;
            inv_dir_q     <= '0;
            tag_q         <= '0;
            best_hit_q    <= 1'b0;
            best_t_q      <= '0;
            best_idx_q    <= '0;
            issue_idx_q   <= '0;
            rsp_idx_q     <= '0;
            outstanding_q <= '0;
            box_count_q   <= '0;
            err_stray_q   <= 1'b0;
        end else begin
            orig_q        <= orig_d;
            inv_dir_q     <= inv_dir_d;
            tag_q         <= tag_d;
            best_hit_q    <= best_hit_d;
            best_t_q      <= best_t_d;
            best_idx_q    <= best_idx_d;
            issue_idx_q   <= issue_idx_d;
            rsp_idx_q     <= rsp_idx_d;
            outstanding_q <= outstanding_d;
            box_count_q   <= box_count_d;
            err_stray_q   <= err_stray_d;
        end
    end

    // Table contents survive reset; only the live count is cleared.
    always_ff @(posedge sysclk) begin
        if (ray_in_ready && cfg_we && ({1'b0, cfg_addr} < MAX_COUNT)) begin
            box_table_q[cfg_addr] <= cfg_box;
        end
    end

endmodule

// File: tb/tb_multi_box_tracer.sv
// Self-checking bench for multi_box_tracer: emulated intersection unit, result scoreboard,
// directed and random rays. Build with ANY_HIT_EN to check the first-hit variant.
module tb_multi_box_tracer;
    import data_structs::*;

    localparam int NB    = 8;
    localparam int IW    = 3;
    localparam int CW    = IW + 1;
    localparam int EXP_W = 1 + IW + 36 + 20;

    typedef struct packed {
        logic          hit;
        logic [IW-1:0] idx;
        fx_t           t;
        logic [19:0]   tag;
    } exp_t;

    typedef struct packed {
        logic hit;
        fx_t  t;
    } rsp_t;

    logic          sysclk = 1'b0;
    logic          rst    = 1'b1;
    logic          ray_in_valid, ray_in_ready;
    vec3_18_18     ray_in_orig, ray_in_inv_dir;
    logic [19:0]   ray_in_tag;
    logic          cfg_we, cfg_count_we;
    logic [IW-1:0] cfg_addr;
    bbox           cfg_box;
    logic [IW:0]   cfg_count;
    logic          isect_req_valid, isect_req_ready;
    vec3_18_18     isect_req_orig, isect_req_inv_dir;
    bbox           isect_req_box;
    range          isect_req_range;
    logic          isect_rsp_valid, isect_rsp_hit;
    logic [35:0]   isect_rsp_t;
    logic          res_valid, res_ready, res_hit;
    logic [IW-1:0] res_idx;
    logic [35:0]   res_t;
    logic [19:0]   res_tag;
    logic          err_stray;
    tracer_state_e dbg_state;

    always #5 sysclk = ~sysclk;

    multi_box_tracer #(.NUM_BOXES(NB), .IDX_W(IW)) dut (
        .sysclk(sysclk), .rst(rst),
        .ray_in_valid(ray_in_valid), .ray_in_ready(ray_in_ready),
        .ray_in_orig(ray_in_orig), .ray_in_inv_dir(ray_in_inv_dir), .ray_in_tag(ray_in_tag),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_box(cfg_box),
        .cfg_count_we(cfg_count_we), .cfg_count(cfg_count),
        .isect_req_valid(isect_req_valid), .isect_req_ready(isect_req_ready),
        .isect_req_orig(isect_req_orig), .isect_req_inv_dir(isect_req_inv_dir),
        .isect_req_box(isect_req_box), .isect_req_range(isect_req_range),
        .isect_rsp_valid(isect_rsp_valid), .isect_rsp_hit(isect_rsp_hit), .isect_rsp_t(isect_rsp_t),
        .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit), .res_idx(res_idx),
        .res_t(res_t), .res_tag(res_tag), .err_stray(err_stray), .dbg_state(dbg_state)
    );

    // Reference state owned by the stimulus process.
    bbox        tb_table [NB];
    logic       hit_tab [NB];
    fx_t        t_tab [NB];
    int         model_count, cur_count, lat, ready_mode, hold_cycles, stray_n;
    vec3_18_18  cur_orig, cur_inv;
    logic [EXP_W-1:0] exp_q[$];

    // Owned by the intersection-unit emulation.
    int         hs_total, req_cnt, cyc, stray_done;

    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic fx_t fx(input int v);
        return fx_t'(longint'(v) * 64'sd262144);
    endfunction

    function automatic vec3_18_18 rand_vec();
        vec3_18_18 v;
        v.x = fx_t'({$urandom(), $urandom()});
        v.y = fx_t'({$urandom(), $urandom()});
        v.z = fx_t'({$urandom(), $urandom()});
        return v;
    endfunction

    function automatic bbox rand_box();
        bbox b;
        b.lo = rand_vec();
        b.hi = rand_vec();
        return b;
    endfunction

    // Expected result from the list of hitting boxes for this ray.
    function automatic logic [EXP_W-1:0] model_result(input int cnt, input logic [19:0] tag);
        exp_t e;
        int   hits[$];
        fx_t  tmin;
        e.hit = 1'b0;
        e.idx = '0;
        e.t   = T_MAX;
        e.tag = tag;
        for (int i = 0; i < cnt; i++) if (hit_tab[i]) hits.push_back(i);
        if (hits.size() != 0) begin
            e.hit = 1'b1;
`ifdef ANY_HIT_EN
            e.idx = IW'(hits[0]);
            e.t   = t_tab[hits[0]];
`else
            tmin = t_tab[hits[0]];
            foreach (hits[k]) if (t_tab[hits[k]] < tmin) tmin = t_tab[hits[k]];
            for (int k = hits.size() - 1; k >= 0; k--) begin
                if (t_tab[hits[k]] == tmin) e.idx = IW'(hits[k]);
            end
            e.t = tmin;
`endif
        end
        return e;
    endfunction

    // Intersection unit emulation: fixed-latency, in-order responses plus request checks.
    initial begin : responder
        rsp_t       pipe_q[$];
        int         due_q[$];
        rsp_t       r;
        logic       pend;
        bbox        pend_box;
        vec3_18_18  pend_orig, pend_inv;
        isect_req_ready = 1'b0;
        isect_rsp_valid = 1'b0;
        isect_rsp_hit   = 1'b0;
        isect_rsp_t     = '0;
        hs_total = 0; req_cnt = 0; cyc = 0; stray_done = 0; pend = 1'b0;
        forever begin
            @(negedge sysclk);
            cyc++;
            if (rst) begin
                pipe_q.delete();
                due_q.delete();
                isect_rsp_valid = 1'b0;
                pend    = 1'b0;
                req_cnt = 0;
                continue;
            end
            case (ready_mode)
                0:       isect_req_ready = 1'b1;
                1:       isect_req_ready = ~isect_req_ready;
                default: isect_req_ready = 1'($urandom_range(0, 1));
            endcase
            isect_rsp_valid = 1'b0;
            isect_rsp_hit   = 1'b0;
            isect_rsp_t     = '0;
            if (stray_done < stray_n) begin
                isect_rsp_valid = 1'b1;
                isect_rsp_hit   = 1'b1;
                isect_rsp_t     = fx(1);
                stray_done++;
            end else if (due_q.size() != 0 && due_q[0] <= cyc) begin
                void'(due_q.pop_front());
                r = pipe_q.pop_front();
                isect_rsp_valid = 1'b1;
                isect_rsp_hit   = r.hit;
                isect_rsp_t     = r.t;
            end
            if (dbg_state == IDLE) req_cnt = 0;
            if (isect_req_valid) begin
                if (pend) begin
                    check("req_stable", (isect_req_box == pend_box) && (isect_req_orig == pend_orig)
                          && (isect_req_inv_dir == pend_inv), 1);
                end
                if (isect_req_ready) begin
                    hs_total++;
                    pend = 1'b0;
                    check("req_in_range", req_cnt < cur_count, 1);
                    if (req_cnt < cur_count) begin
                        check("req_box", isect_req_box == tb_table[req_cnt], 1);
                        check("req_orig", isect_req_orig == cur_orig, 1);
                        check("req_inv_dir", isect_req_inv_dir == cur_inv, 1);
                        check("req_range", isect_req_range == {T_MIN, T_MAX}, 1);
                        r.hit = hit_tab[req_cnt];
                        r.t   = t_tab[req_cnt];
                        pipe_q.push_back(r);
                        due_q.push_back(cyc + lat);
                    end
                    req_cnt++;
                end else begin
                    pend      = 1'b1;
                    pend_box  = isect_req_box;
                    pend_orig = isect_req_orig;
                    pend_inv  = isect_req_inv_dir;
                end
            end else begin
                if (pend) check("req_valid_held", isect_req_valid, 1);
                pend = 1'b0;
            end
        end
    end

    // Result monitor: optional back-pressure, stability, then scoreboard compare.
    initial begin : monitor
        logic             seen;
        int               hold_left;
        exp_t             e;
        logic [EXP_W-1:0] cap;
        res_ready = 1'b0;
        seen      = 1'b0;
        hold_left = 0;
        forever begin
            @(negedge sysclk);
            if (rst || !res_valid) begin
                res_ready = 1'b0;
                seen      = 1'b0;
            end else begin
                if (!seen) begin
                    seen      = 1'b1;
                    cap       = {res_hit, res_idx, res_t, res_tag};
                    hold_left = hold_cycles;
                end else begin
                    check("res_stable", {res_hit, res_idx, res_t, res_tag} == cap, 1);
                end
                if (hold_left > 0) begin
                    check("ray_ready_in_done", ray_in_ready, 0);
                    hold_left--;
                    res_ready = 1'b0;
                end else if (res_ready) begin
                    check("res_valid_after_ready", res_valid, 0);
                end else begin
                    res_ready = 1'b1;
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", res_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("res_hit", res_hit, e.hit);
                        check("res_tag", res_tag, e.tag);
                        check("res_t", res_t, {28'b0, e.t});
                        if (e.hit) check("res_idx", res_idx, e.idx);
                    end
                end
            end
        end
    end

    task automatic cfg_write_box(input int addr, input bbox b, input bit taken);
        cfg_we   = 1'b1;
        cfg_addr = IW'(addr);
        cfg_box  = b;
        if (taken) tb_table[addr] = b;
        @(negedge sysclk);
        cfg_we = 1'b0;
    endtask

    task automatic cfg_set_count(input int cnt, input bit taken);
        cfg_count_we = 1'b1;
        cfg_count    = CW'(cnt);
        if (taken) model_count = (cnt > NB) ? NB : cnt;
        @(negedge sysclk);
        cfg_count_we = 1'b0;
    endtask

    task automatic clear_hits();
        for (int i = 0; i < NB; i++) begin
            hit_tab[i] = 1'b0;
            t_tab[i]   = '0;
        end
    endtask

    task automatic send_ray(input logic [19:0] tag, input bit expect_result);
        int n = 0;
        while (!ray_in_ready && n < 1000) begin
            @(negedge sysclk);
            n++;
        end
        check("ray_ready_timeout", ray_in_ready, 1);
        cur_count      = model_count;
        cur_orig       = rand_vec();
        cur_inv        = rand_vec();
        ray_in_valid   = 1'b1;
        ray_in_orig    = cur_orig;
        ray_in_inv_dir = cur_inv;
        ray_in_tag     = tag;
        if (expect_result) exp_q.push_back(model_result(model_count, tag));
        @(negedge sysclk);
        ray_in_valid = 1'b0;
    endtask

    task automatic wait_results();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge sysclk);
            n++;
        end
        check("result_timeout", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge sysclk);
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int snap;
        int n;
        ray_in_valid = 1'b0; ray_in_orig = '0; ray_in_inv_dir = '0; ray_in_tag = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_box = '0; cfg_count_we = 1'b0; cfg_count = '0;
        lat = 4; ready_mode = 0; hold_cycles = 0; stray_n = 0;
        model_count = 0; cur_count = 0;
        clear_hits();

        rst = 1'b1;
        repeat (3) @(negedge sysclk);
        rst = 1'b0;
        @(negedge sysclk);
        check("rst_state", dbg_state, IDLE);
        check("rst_ray_ready", ray_in_ready, 1);
        check("rst_req_valid", isect_req_valid, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_bus", {res_hit, res_idx, res_t, res_tag}, 0);
        check("rst_err_stray", err_stray, 0);

        for (int i = 0; i < NB; i++) cfg_write_box(i, rand_box(), 1'b1);

        // Closest of two hits, fixed latency 4.
        cfg_set_count(3, 1'b1);
        clear_hits();
        hit_tab[0] = 1'b1; t_tab[0] = fx(5);
        hit_tab[2] = 1'b1; t_tab[2] = fx(2);
        send_ray(20'h2A_155, 1'b1);
        wait_results();

        // Equal distances: lower index wins.
        cfg_set_count(5, 1'b1);
        clear_hits();
        hit_tab[1] = 1'b1; t_tab[1] = fx(3);
        hit_tab[4] = 1'b1; t_tab[4] = fx(3);
        send_ray(20'h01_002, 1'b1);
        wait_results();

        // Empty table: immediate miss, no requests.
        cfg_set_count(0, 1'b1);
        snap = hs_total;
        send_ray(20'hF_0F0F, 1'b1);
        wait_results();
        check("count0_no_req", hs_total - snap, 0);

        // Request back-pressure toggling every cycle over the full table.
        cfg_set_count(8, 1'b1);
        clear_hits();
        for (int i = 0; i < NB; i++) begin
            hit_tab[i] = 1'($urandom_range(0, 1));
            t_tab[i]   = fx($urandom_range(0, 40) - 20);
        end
        ready_mode = 1;
        snap = hs_total;
        send_ray(20'h3_3333, 1'b1);
        wait_results();
`ifdef ANY_HIT_EN
        check("toggle_hs_bound", hs_total - snap <= 8, 1);
`else
        check("toggle_hs_count", hs_total - snap, 8);
`endif
        ready_mode = 0;

        // Result back-pressure for 10 cycles; config writes during the ray are dropped.
        cfg_set_count(4, 1'b1);
        clear_hits();
        hold_cycles = 10;
        send_ray(20'h4_4444, 1'b1);
        n = 0;
        while (!res_valid && n < 200) begin
            @(negedge sysclk);
            n++;
        end
        check("hold_res_seen", res_valid, 1);
        cfg_write_box(0, rand_box(), 1'b0);
        cfg_set_count(2, 1'b0);
        wait_results();
        hold_cycles = 0;
        snap = hs_total;
        send_ray(20'h5_5555, 1'b1);
        wait_results();
        check("dropped_count_write", hs_total - snap, 4);

        // Oversized count saturates to the table depth.
        cfg_set_count(12, 1'b1);
        clear_hits();
        snap = hs_total;
        send_ray(20'h6_6666, 1'b1);
        wait_results();
        check("count_saturate", hs_total - snap, 8);

        // Randomised rays against the reference model.
        for (int r = 0; r < 12; r++) begin
            cfg_write_box($urandom_range(0, NB - 1), rand_box(), 1'b1);
            cfg_set_count($urandom_range(1, NB), 1'b1);
            for (int i = 0; i < NB; i++) begin
                hit_tab[i] = 1'($urandom_range(0, 1));
                t_tab[i]   = fx($urandom_range(0, 8) - 4);
            end
            lat         = $urandom_range(1, 6);
            ready_mode  = $urandom_range(0, 2);
            hold_cycles = $urandom_range(0, 3);
            send_ray(20'($urandom()), 1'b1);
            wait_results();
        end
        lat = 4; ready_mode = 0; hold_cycles = 0;

        // Early hit at index 1 with closer hits later in the table.
        cfg_set_count(8, 1'b1);
        clear_hits();
        hit_tab[1] = 1'b1; t_tab[1] = fx(7);
        hit_tab[3] = 1'b1; t_tab[3] = fx(1);
        hit_tab[6] = 1'b1; t_tab[6] = fx_t'(36'sd131072);
        snap = hs_total;
        send_ray(20'h7_7777, 1'b1);
        wait_results();
`ifdef ANY_HIT_EN
        check("anyhit_fewer_reqs", hs_total - snap < 8, 1);
`else
        check("closest_all_reqs", hs_total - snap, 8);
`endif
        check("no_stray_yet", err_stray, 0);

        // Reset while draining, then two late responses.
        lat = 30;
        clear_hits();
        send_ray(20'h8_8888, 1'b0);
        n = 0;
        while (dbg_state != DRAIN && n < 200) begin
            @(negedge sysclk);
            n++;
        end
        check("reach_drain", dbg_state, DRAIN);
        rst = 1'b1;
        @(negedge sysclk);
        rst = 1'b0;
        model_count = 0;
        check("midray_rst_state", dbg_state, IDLE);
        check("midray_rst_stray", err_stray, 0);
        stray_n = stray_n + 2;
        repeat (10) @(negedge sysclk);
        check("late_rsp_stray", err_stray, 1);
        check("late_rsp_no_result", res_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_box_tracer.md
MULTI_BOX_TRACER -- requirements
Module: multi_box_tracer

Interface
REQ-001 SHALL have parameter NUM_BOXES, default 8, meaning box-table depth (2..64).
REQ-002 SHALL have parameter IDX_W, default $clog2(NUM_BOXES), meaning box-index width.
REQ-003 SHALL have ports sysclk in 1 (sole clock) and rst in 1 (reset, asynchronous, active-high).
REQ-004 SHALL have ports ray_in_valid in 1, ray_in_ready out 1, ray_in_orig in vec3_18_18, ray_in_inv_dir in vec3_18_18, ray_in_tag in 20 ({pixel_y[9:0], pixel_x[9:0]}).
REQ-005 SHALL have ports cfg_we in 1, cfg_addr in IDX_W, cfg_box in bbox, cfg_count_we in 1, cfg_count in IDX_W+1.
REQ-006 SHALL have ports isect_req_valid out 1, isect_req_ready in 1, isect_req_orig out vec3_18_18, isect_req_inv_dir out vec3_18_18, isect_req_box out bbox, isect_req_range out range.
REQ-007 SHALL have ports isect_rsp_valid in 1, isect_rsp_hit in 1, isect_rsp_t in 36 (signed 18.18 entry distance).
REQ-008 SHALL have ports res_valid out 1, res_ready in 1, res_hit out 1, res_idx out IDX_W, res_t out 36, res_tag out 20, err_stray out 1 (sticky).

Function
REQ-009 SHALL implement states IDLE, ISSUE, DRAIN, DONE; ray_in_ready=1 only in IDLE.
REQ-010 SHALL, on ray_in_valid&&ray_in_ready, latch orig, inv_dir and tag, clear best_hit, set best_t=T_MAX, issue index=0, outstanding=0, and enter ISSUE, or DONE with res_hit=0 if box_count==0.
REQ-011 SHALL in ISSUE drive isect_req_valid=1 with box_table[issue index] and range {T_MIN,T_MAX}; issue index increments on each req handshake; after handshake of index box_count-1, go to DRAIN next cycle.
REQ-012 SHALL keep isect_req_* payload stable while isect_req_valid=1 and isect_req_ready=0.
REQ-013 SHALL increment outstanding on req handshake, decrement on isect_rsp_valid, and leave it unchanged on both in one cycle.
REQ-014 SHALL treat responses as in issue order and tag each with the index counted by a separate response counter.
REQ-015 SHALL update best on a hit response when !best_hit or t strictly less than best_t (signed compare); ties keep the lower index.
REQ-016 SHALL leave DRAIN for DONE in the cycle after outstanding reaches 0 with no request pending.
REQ-017 SHALL in DONE hold res_valid=1 with stable res_* until res_ready, then return to IDLE; a new ray is accepted at the earliest the following cycle.
REQ-018 SHALL, for isect_rsp_valid with outstanding==0, ignore the response and set err_stray until reset.
REQ-019 SHALL write the box table and box_count only in IDLE; writes in other states are dropped; cfg_count>NUM_BOXES saturates to NUM_BOXES.

Reset
REQ-020 SHALL on rst force IDLE, zero all counters, box_count=0, res_*=0, isect_req_valid=0, err_stray=0; box table contents are not reset.
REQ-021 SHALL on rst mid-ray abandon the ray without emitting a result; later responses from the abandoned ray set err_stray.

Configuration
REQ-022 SHALL, with ANY_HIT_EN defined, stop issuing on the first hit response, enter DRAIN, discard later responses without counting them as stray, and report that first hit's index and t.
REQ-023 SHALL, without ANY_HIT_EN, perform closest-hit over all box_count boxes per REQ-015.

Structure
REQ-024 SHALL take vec3_18_18, bbox, range, T_MIN, T_MAX and a new tracer_state_e enum from data_structs.
REQ-025 SHALL be a single module with no sub-modules; the box table is a register array.

Verification
REQ-026 SHALL test count=3, boxes 0 and 2 hit t=5.0 and 2.0, model latency 4 -> res_hit=1, res_idx=2, res_t=2.0, tag echoed.
REQ-027 SHALL test equal t=3.0 on indices 1 and 4 -> res_idx=1; count=0 -> res_valid with res_hit=0 and no isect_req_valid.
REQ-028 SHALL test isect_req_ready toggled 1/0 every cycle, count=8 -> exactly 8 handshakes, stable payload, correct closest hit.
REQ-029 SHALL test res_ready held 0 for 10 cycles -> res_* stable, ray_in_ready=0 throughout; cfg_we during ray -> table unchanged.
REQ-030 SHALL test rst mid-DRAIN, then 2 late responses -> no res_valid, err_stray=1; ANY_HIT_EN build with hit at index 1 of 8 -> res_idx=1, fewer than 8 requests issued.
